imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 108 ++++++++++
 tb/tb_imem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction memory responder: one outstanding fetch, fixed response latency,
// fault/NOP response for misaligned or out-of-range addresses, and a program-load write port.
module imem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_instr,
   output logic        resp_fault,
   input  logic        flush,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);

   // state | meaning
   // IDLE  | ready for a new fetch request
   // BUSY  | request latched, latency counter running down to 0
   // RESP  | response presented, waiting for resp_ready

   localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] NOP_INSTR = 32'hC800_0000;
   localparam logic [3:0]  LAT_LOAD  = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt;
   logic [AW-1:0] idx_q;
   logic          fault_q;
   logic [31:0]   mem [DEPTH_WORDS];

   logic req_fault, load_ok, accept, sample;

   assign req_fault = (req_addr[1:0] != 2'b00) ||
                      ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign load_ok   = load_en && (load_addr[1:0] == 2'b00) &&
                      ({2'b00, load_addr[31:2]} < 32'(DEPTH_WORDS));

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // flush wins over both a new request and a pending sample
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      sample    = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && !flush) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (flush) begin
               state_nxt = IDLE;
            end else if (cnt == 4'd0) begin
               sample    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (flush || resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= 4'd0;
         idx_q      <= '0;
         fault_q    <= 1'b0;
         resp_instr <= 32'h0;
         resp_fault <= 1'b0;
      end else begin
         if (accept) begin
            cnt     <= LAT_LOAD;
            idx_q   <= req_addr[AW+1:2];
            fault_q <= req_fault;
         end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (sample) begin
            resp_instr <= fault_q ? NOP_INSTR : mem[idx_q];
            resp_fault <= fault_q;
         end
      end
   end

   // Memory is not reset; a same-cycle load and sample sees the old word.
   always_ff @(posedge clk) begin
      if (!rst && load_ok) mem[load_addr[AW+1:2]] <= load_data;
   end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboarded bench for imem_responder: directed scenarios followed by random
// fetch/load/flush/reset traffic, checked against a transaction-level memory model.
module tb_imem_responder;

   localparam int          DEPTH = 256;
   localparam int          LAT   = 2;
   localparam logic [31:0] NOP   = 32'hC800_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_instr;
   logic        resp_fault;
   logic        flush = 1'b0;
   logic        load_en = 1'b0;
   logic [31:0] load_addr = 32'h0;
   logic [31:0] load_data = 32'h0;

   imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_instr(resp_instr), .resp_fault(resp_fault),
      .flush(flush),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        fault;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_mem [DEPTH];
   bit          m_busy = 0, m_sampled = 0, m_fault = 0;
   int          m_idx = 0, m_due = 0;
   int          cyc = 0;
   bit          checking = 0, prev_valid = 0;
   int          n_cmp = 0, n_bad = 0;

   function automatic bit is_bad(input logic [31:0] a);
      return ((a % 4) != 0) || ((a / 4) >= DEPTH);
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
      end
   endfunction

   // Reference model: one outstanding fetch, answered LAT edges after acceptance,
   // with the memory word as it stood before that edge's load.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_busy = 0;
         m_sampled = 0;
         exp_q.delete();
      end else begin
         if (m_busy) begin
            if (flush) begin
               if (m_sampled && exp_q.size() > 0) void'(exp_q.pop_back());
               m_busy = 0;
               m_sampled = 0;
            end else if (m_sampled) begin
               if (resp_ready) begin
                  m_busy = 0;
                  m_sampled = 0;
               end
            end else if (cyc == m_due) begin
               exp_q.push_back('{instr: m_fault ? NOP : m_mem[m_idx], fault: m_fault, due: m_due});
               m_sampled = 1;
            end
         end else if (req_valid && !flush) begin
            m_busy    = 1;
            m_sampled = 0;
            m_fault   = is_bad(req_addr);
            m_idx     = m_fault ? 0 : int'(req_addr / 4);
            m_due     = cyc + LAT;
         end
         if (load_en && !is_bad(load_addr)) m_mem[int'(load_addr / 4)] = load_data;
      end
   end

   // Monitor: handshake-level response checking plus ready/valid against the model.
   always @(negedge clk) begin
      if (checking) begin
         check("req_ready", 32'(req_ready), 32'(!m_busy));
         check("resp_valid", 32'(resp_valid), 32'(m_busy && m_sampled));
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               check("resp_unexpected", 32'(resp_valid), 32'h0);
            end else begin
               if (!prev_valid) check("latency", 32'(cyc), 32'(exp_q[0].due));
               check("resp_instr", resp_instr, exp_q[0].instr);
               check("resp_fault", 32'(resp_fault), 32'(exp_q[0].fault));
               if (resp_ready && !flush && !rst) void'(exp_q.pop_front());
            end
         end
         prev_valid = resp_valid;
      end
   end

   task automatic drive(input bit r, input bit rv, input logic [31:0] ra, input bit rr,
                        input bit fl, input bit le, input logic [31:0] la, input logic [31:0] ld);
      rst = r; req_valid = rv; req_addr = ra; resp_ready = rr;
      flush = fl; load_en = le; load_addr = la; load_data = ld;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0:       a = $urandom;
         1:       a = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
         2:       a = 32'h400 + ($urandom_range(0, 63) << 2);
         default: a = $urandom_range(0, DEPTH - 1) << 2;
      endcase
      return a;
   endfunction

   initial begin
      drive(1, 1, 32'h4, 1, 1, 0, 32'h0, 32'h0);
      drive(1, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
      drive(0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
      checking = 1;
      check("rst_instr", resp_instr, 32'h0);
      check("rst_fault", 32'(resp_fault), 32'h0);
      check("rst_ready", 32'(req_ready), 32'h1);

      for (int i = 0; i < DEPTH; i++) drive(0, 0, 32'h0, 1, 0, 1, 32'(i * 4), $urandom);
      drive(1, 0, 32'h0, 1, 0, 1, 32'h14, 32'hDEAD_BEEF);   // load under reset is dropped
      idle(1);

      drive(0, 0, 32'h0, 1, 0, 1, 32'h4, 32'h1234_5678);
      drive(0, 1, 32'h4, 1, 0, 0, 32'h0, 32'h0);
      idle(4);

      drive(0, 1, 32'h6, 1, 0, 0, 32'h0, 32'h0);
      idle(3);
      drive(0, 1, 32'h400, 1, 0, 0, 32'h0, 32'h0);
      idle(3);

      drive(0, 1, 32'h8, 0, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 7; i++) drive(0, 1, 32'hC, 0, 0, 0, 32'h0, 32'h0);
      drive(0, 1, 32'hC, 1, 0, 0, 32'h0, 32'h0);
      drive(0, 1, 32'hC, 1, 0, 0, 32'h0, 32'h0);
      idle(4);

      drive(0, 1, 32'h10, 1, 0, 0, 32'h0, 32'h0);
      drive(0, 0, 32'h0, 1, 1, 0, 32'h0, 32'h0);
      drive(0, 1, 32'h8, 1, 0, 0, 32'h0, 32'h0);
      idle(4);
      drive(0, 1, 32'h8, 0, 1, 0, 32'h0, 32'h0);           // flush blocks acceptance in IDLE
      idle(2);

      drive(0, 1, 32'h4, 1, 0, 0, 32'h0, 32'h0);
      drive(0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
      drive(0, 0, 32'h0, 1, 0, 1, 32'h4, 32'hAAAA_AAAA);
      idle(2);
      drive(0, 1, 32'h4, 1, 0, 0, 32'h0, 32'h0);
      idle(4);

      drive(0, 1, 32'h4, 0, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      drive(1, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
      drive(0, 1, 32'h14, 1, 0, 0, 32'h0, 32'h0);
      idle(4);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] la;
         la = ($urandom_range(0, 7) == 0) ? rand_addr() : ($urandom_range(0, DEPTH - 1) << 2);
         drive($urandom_range(0, 199) == 0,
               $urandom_range(0, 1) == 1, rand_addr(),
               $urandom_range(0, 9) < 6,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 4) == 0, la, $urandom);
      end
      idle(LAT + 4);

      check("drained_queue", 32'(exp_q.size()), 32'h0);
      check("drained_busy", 32'(m_busy), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
